// File: rtl/wr_streamer_pair.sv
// Paired record streamer: TX packs buffered records into frames on a 16-bit pipelined
// Wishbone source; RX filters frames from a sink, unpacks records, tracks sequence and latency.
module wr_streamer_pair #(
  parameter int g_data_width     = 64,
  parameter int g_tx_threshold   = 8,
  parameter int g_tx_buffer_size = 16,
  parameter int g_tx_max_records = 16,
  parameter int g_tx_timeout     = 512,
  parameter int g_rx_buffer_size = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [27:0]             tm_cycles_i,
  input  logic [47:0]             cfg_mac_tx_i,
  input  logic [47:0]             cfg_mac_rx_i,
  input  logic [15:0]             cfg_ethertype_i,
  input  logic [g_data_width-1:0] tx_data_i,
  input  logic                    tx_valid_i,
  output logic                    tx_dreq_o,
  output logic [15:0]             src_dat_o,
  output logic [1:0]              src_adr_o,
  output logic [1:0]              src_sel_o,
  output logic                    src_cyc_o,
  output logic                    src_stb_o,
  output logic                    src_we_o,
  input  logic                    src_stall_i,
  input  logic                    src_ack_i,
  input  logic                    src_err_i,
  input  logic [15:0]             snk_dat_i,
  input  logic [1:0]              snk_adr_i,
  input  logic [1:0]              snk_sel_i,
  input  logic                    snk_cyc_i,
  input  logic                    snk_stb_i,
  input  logic                    snk_we_i,
  output logic                    snk_stall_o,
  output logic                    snk_ack_o,
  output logic                    snk_err_o,
  output logic                    snk_rty_o,
  output logic [g_data_width-1:0] rx_data_o,
  output logic                    rx_valid_o,
  input  logic                    rx_dreq_i,
  output logic                    rx_lost_o,
  output logic [27:0]             rx_latency_o,
  output logic                    rx_latency_valid_o
);
  localparam int W  = g_data_width / 16;
  localparam int WK = (W > 1) ? $clog2(W) : 1;
  localparam int TA = $clog2(g_tx_buffer_size);
  localparam int TC = $clog2(g_tx_buffer_size + 1);
  localparam int RA = $clog2(g_rx_buffer_size);
  localparam int RC = $clog2(g_rx_buffer_size + 1);
  localparam int TO = $clog2(g_tx_timeout + 1);
  localparam logic [TA-1:0] TX_LAST = TA'(g_tx_buffer_size - 1);
  localparam logic [RA-1:0] RX_LAST = RA'(g_rx_buffer_size - 1);
  localparam logic [WK-1:0] WK_LAST = WK'(W - 1);

  typedef enum logic [1:0] {S_IDLE, S_HEADER, S_DATA, S_WAIT} tx_state_t;
  typedef enum logic [1:0] {R_HDR, R_DATA, R_SKIP} rx_state_t;

  // Fabric words within a record go out most-significant first.
  function automatic logic [15:0] rec_word(input logic [g_data_width-1:0] rec,
                                           input logic [WK-1:0] k);
    return rec[(W - 1 - int'(k)) * 16 +: 16];
  endfunction

  tx_state_t               tx_st;
  logic [g_data_width-1:0] tx_mem [g_tx_buffer_size];
  logic [TA-1:0]           tx_wr, tx_rd, tx_wr_inc, tx_rd_inc;
  logic [TC-1:0]           tx_cnt, tx_cnt_nxt;
  logic                    tx_push, tx_pop, adv, launch;
  logic [TO-1:0]           to_cnt;
  logic [3:0]              hdr_idx;
  logic [WK-1:0]           wk;
  logic [15:0]             rec_idx, nrec, n_launch, seq_l, tx_seq;
  logic [27:0]             ts_l;
  logic [7:0]              outst, outst_nxt;

  function automatic logic [15:0] hdr_word(input logic [3:0] idx);
    case (idx)
      4'd0:    return cfg_mac_rx_i[47:32];
      4'd1:    return cfg_mac_rx_i[31:16];
      4'd2:    return cfg_mac_rx_i[15:0];
      4'd3:    return cfg_mac_tx_i[47:32];
      4'd4:    return cfg_mac_tx_i[31:16];
      4'd5:    return cfg_mac_tx_i[15:0];
      4'd6:    return cfg_ethertype_i;
      4'd7:    return seq_l;
      4'd8:    return ts_l[27:12];
      4'd9:    return {4'h0, ts_l[11:0]};
      default: return nrec;
    endcase
  endfunction

  assign tx_wr_inc  = (tx_wr == TX_LAST) ? '0 : tx_wr + 1'b1;
  assign tx_rd_inc  = (tx_rd == TX_LAST) ? '0 : tx_rd + 1'b1;
  assign adv        = src_stb_o && !src_stall_i;
  assign tx_pop     = (tx_st == S_DATA) && adv && !src_err_i && (wk == WK_LAST);
  assign tx_push    = tx_valid_i && ((tx_cnt != TC'(g_tx_buffer_size)) || tx_pop);
  assign tx_cnt_nxt = tx_cnt + TC'(tx_push) - TC'(tx_pop);
  assign outst_nxt  = outst + 8'(adv) - 8'(src_ack_i);
  assign launch     = (tx_st == S_IDLE) &&
                      ((tx_cnt >= TC'(g_tx_threshold)) ||
                       ((tx_cnt != '0) && (to_cnt == TO'(g_tx_timeout))));
  assign n_launch   = (int'(tx_cnt) > g_tx_max_records) ? 16'(g_tx_max_records) : 16'(tx_cnt);

  always_ff @(posedge clk)
    if (tx_push) tx_mem[tx_wr] <= tx_data_i;

  always_ff @(posedge clk) begin
    if (!rst) begin
      tx_wr     <= '0;
      tx_rd     <= '0;
      tx_cnt    <= '0;
      tx_dreq_o <= 1'b0;
    end else begin
      if (tx_push) tx_wr <= tx_wr_inc;
      if (tx_pop)  tx_rd <= tx_rd_inc;
      tx_cnt    <= tx_cnt_nxt;
      tx_dreq_o <= (int'(tx_cnt_nxt) <= g_tx_buffer_size - 2);
    end
  end

  // TX fabric source
  always_ff @(posedge clk) begin
    if (!rst) begin
      tx_st     <= S_IDLE;
      src_cyc_o <= 1'b0;
      src_stb_o <= 1'b0;
      src_we_o  <= 1'b0;
      src_sel_o <= 2'b00;
      src_adr_o <= 2'b00;
      src_dat_o <= '0;
      hdr_idx   <= '0;
      wk        <= '0;
      rec_idx   <= '0;
      nrec      <= '0;
      tx_seq    <= '0;
      outst     <= '0;
      to_cnt    <= '0;
    end else if (tx_st != S_IDLE && src_err_i) begin
      tx_st     <= S_IDLE;
      src_cyc_o <= 1'b0;
      src_stb_o <= 1'b0;
      src_we_o  <= 1'b0;
      src_sel_o <= 2'b00;
      outst     <= '0;
    end else begin
      case (tx_st)
        S_IDLE: begin
          outst <= '0;
          if (launch) begin
            to_cnt    <= '0;
            nrec      <= n_launch;
            ts_l      <= tm_cycles_i;
            seq_l     <= tx_seq;
            tx_seq    <= tx_seq + 16'd1;
            hdr_idx   <= '0;
            wk        <= '0;
            rec_idx   <= '0;
            src_cyc_o <= 1'b1;
            src_stb_o <= 1'b1;
            src_we_o  <= 1'b1;
            src_sel_o <= 2'b11;
            src_dat_o <= cfg_mac_rx_i[47:32];
            tx_st     <= S_HEADER;
          end else if (tx_cnt_nxt != '0) begin
            to_cnt <= to_cnt + 1'b1;
          end else begin
            to_cnt <= '0;
          end
        end
        S_HEADER: begin
          outst <= outst_nxt;
          if (adv) begin
            if (hdr_idx == 4'd10) begin
              tx_st     <= S_DATA;
              src_dat_o <= rec_word(tx_mem[tx_rd], '0);
            end else begin
              hdr_idx   <= hdr_idx + 4'd1;
              src_dat_o <= hdr_word(hdr_idx + 4'd1);
            end
          end
        end
        S_DATA: begin
          outst <= outst_nxt;
          if (adv) begin
            if (wk == WK_LAST) begin
              wk <= '0;
              if (rec_idx == nrec - 16'd1) begin
                src_stb_o <= 1'b0;
                tx_st     <= S_WAIT;
              end else begin
                rec_idx   <= rec_idx + 16'd1;
                src_dat_o <= rec_word(tx_mem[tx_rd_inc], '0);
              end
            end else begin
              wk        <= wk + 1'b1;
              src_dat_o <= rec_word(tx_mem[tx_rd], wk + 1'b1);
            end
          end
        end
        default: begin
          outst <= outst_nxt;
          if (outst_nxt == '0) begin
            src_cyc_o <= 1'b0;
            src_we_o  <= 1'b0;
            src_sel_o <= 2'b00;
            tx_st     <= S_IDLE;
          end
        end
      endcase
    end
  end

  rx_state_t                rx_st;
  logic [g_data_width-1:0]  rx_mem [g_rx_buffer_size];
  logic [g_data_width-17:0] rx_sr;
  logic [g_data_width-1:0]  rx_rec;
  logic [RA-1:0]            rx_wr, rx_rd;
  logic [RC-1:0]            rx_cnt;
  logic                     acc, rx_push, rx_pop, hdr_ok, seq_seen;
  logic [3:0]               rx_idx;
  logic [WK-1:0]            rk;
  logic [15:0]              rn, rrec, exp_seq;
  logic [27:0]              rts;
  logic                     unused_snk;

  assign unused_snk  = ^{snk_adr_i, snk_sel_i, snk_we_i};
  assign snk_stall_o = (rx_cnt == RC'(g_rx_buffer_size));
  assign snk_err_o   = 1'b0;
  assign snk_rty_o   = 1'b0;
  assign acc         = snk_cyc_i && snk_stb_i && !snk_stall_o;
  assign rx_rec      = {rx_sr, snk_dat_i};
  assign rx_push     = acc && (rx_st == R_DATA) && (rk == WK_LAST);
  assign rx_pop      = rx_dreq_i && (rx_cnt != '0);

  // RX fabric sink
  always_ff @(posedge clk) begin
    if (!rst) begin
      rx_st              <= R_HDR;
      rx_idx             <= '0;
      hdr_ok             <= 1'b1;
      seq_seen           <= 1'b0;
      exp_seq            <= '0;
      rk                 <= '0;
      rrec               <= '0;
      rn                 <= '0;
      snk_ack_o          <= 1'b0;
      rx_lost_o          <= 1'b0;
      rx_latency_o       <= '0;
      rx_latency_valid_o <= 1'b0;
    end else begin
      snk_ack_o          <= acc;
      rx_lost_o          <= 1'b0;
      rx_latency_valid_o <= 1'b0;
      if (!snk_cyc_i) begin
        rx_st  <= R_HDR;
        rx_idx <= '0;
        hdr_ok <= 1'b1;
        rk     <= '0;
        rrec   <= '0;
      end else if (acc) begin
        case (rx_st)
          R_HDR: begin
            rx_idx <= rx_idx + 4'd1;
            case (rx_idx)
              4'd0: hdr_ok <= hdr_ok && (snk_dat_i == cfg_mac_rx_i[47:32]);
              4'd1: hdr_ok <= hdr_ok && (snk_dat_i == cfg_mac_rx_i[31:16]);
              4'd2: hdr_ok <= hdr_ok && (snk_dat_i == cfg_mac_rx_i[15:0]);
              4'd3: hdr_ok <= hdr_ok && (snk_dat_i == cfg_mac_tx_i[47:32]);
              4'd4: hdr_ok <= hdr_ok && (snk_dat_i == cfg_mac_tx_i[31:16]);
              4'd5: hdr_ok <= hdr_ok && (snk_dat_i == cfg_mac_tx_i[15:0]);
              4'd6: hdr_ok <= hdr_ok && (snk_dat_i == cfg_ethertype_i);
              4'd7: if (hdr_ok) begin
                rx_lost_o <= seq_seen && (snk_dat_i != exp_seq);
                exp_seq   <= snk_dat_i + 16'd1;
                seq_seen  <= 1'b1;
              end
              4'd8: rts[27:12] <= snk_dat_i;
              4'd9: rts[11:0]  <= snk_dat_i[11:0];
              default: begin
                rn    <= snk_dat_i;
                rx_st <= (hdr_ok && snk_dat_i != 16'd0) ? R_DATA : R_SKIP;
              end
            endcase
          end
          R_DATA: begin
            rx_sr <= rx_rec[g_data_width-17:0];
            if (rk == WK_LAST) begin
              rk   <= '0;
              rrec <= rrec + 16'd1;
              if (rrec == rn - 16'd1) begin
                rx_latency_o       <= tm_cycles_i - rts;
                rx_latency_valid_o <= 1'b1;
                rx_st              <= R_SKIP;
              end
            end else begin
              rk <= rk + 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk)
    if (rx_push) rx_mem[rx_wr] <= rx_rec;

  always_ff @(posedge clk) begin
    if (!rst) begin
      rx_wr      <= '0;
      rx_rd      <= '0;
      rx_cnt     <= '0;
      rx_valid_o <= 1'b0;
      rx_data_o  <= '0;
    end else begin
      if (rx_push) rx_wr <= (rx_wr == RX_LAST) ? '0 : rx_wr + 1'b1;
      if (rx_pop) begin
        rx_rd     <= (rx_rd == RX_LAST) ? '0 : rx_rd + 1'b1;
        rx_data_o <= rx_mem[rx_rd];
      end
      rx_valid_o <= rx_pop;
      rx_cnt     <= rx_cnt + RC'(rx_push) - RC'(rx_pop);
    end
  end
endmodule

// File: tb/tb_wr_streamer_pair.sv
// Directed bench for wr_streamer_pair: TX frame format and timeout, RX filtering,
// sequence-gap, latency and truncation handling, then a src->snk loopback run.
module tb_wr_streamer_pair;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [27:0] tm_cycles_i = '0;
  logic [47:0] mac_tx = 48'h0266_7788_99AA;
  logic [47:0] mac_rx = 48'h0211_2233_4455;
  logic [15:0] ethertype = 16'hDBFF;
  logic [63:0] tx_data_i = '0;
  logic        tx_valid_i = 1'b0;
  logic        tx_dreq_o;
  logic [15:0] src_dat_o;
  logic [1:0]  src_adr_o, src_sel_o;
  logic        src_cyc_o, src_stb_o, src_we_o;
  logic        src_stall_i, src_ack_i, src_err_i;
  logic [15:0] snk_dat_i;
  logic [1:0]  snk_adr_i, snk_sel_i;
  logic        snk_cyc_i, snk_stb_i, snk_we_i;
  logic        snk_stall_o, snk_ack_o, snk_err_o, snk_rty_o;
  logic [63:0] rx_data_o;
  logic        rx_valid_o, rx_lost_o, rx_latency_valid_o;
  logic        rx_dreq_i = 1'b0;
  logic [27:0] rx_latency_o;

  logic        loopback = 1'b0;
  logic [15:0] sk_dat = '0;
  logic        sk_cyc = 1'b0, sk_stb = 1'b0;
  logic        tb_stall = 1'b0, tb_ack = 1'b0, ack_pend = 1'b0;

  assign snk_dat_i   = loopback ? src_dat_o : sk_dat;
  assign snk_adr_i   = loopback ? src_adr_o : 2'b00;
  assign snk_sel_i   = loopback ? src_sel_o : 2'b11;
  assign snk_cyc_i   = loopback ? src_cyc_o : sk_cyc;
  assign snk_stb_i   = loopback ? src_stb_o : sk_stb;
  assign snk_we_i    = loopback ? src_we_o : 1'b1;
  assign src_stall_i = loopback ? snk_stall_o : tb_stall;
  assign src_ack_i   = loopback ? snk_ack_o : tb_ack;
  assign src_err_i   = 1'b0;

  wr_streamer_pair dut (
    .clk(clk), .rst(rst), .tm_cycles_i(tm_cycles_i),
    .cfg_mac_tx_i(mac_tx), .cfg_mac_rx_i(mac_rx), .cfg_ethertype_i(ethertype),
    .tx_data_i(tx_data_i), .tx_valid_i(tx_valid_i), .tx_dreq_o(tx_dreq_o),
    .src_dat_o(src_dat_o), .src_adr_o(src_adr_o), .src_sel_o(src_sel_o),
    .src_cyc_o(src_cyc_o), .src_stb_o(src_stb_o), .src_we_o(src_we_o),
    .src_stall_i(src_stall_i), .src_ack_i(src_ack_i), .src_err_i(src_err_i),
    .snk_dat_i(snk_dat_i), .snk_adr_i(snk_adr_i), .snk_sel_i(snk_sel_i),
    .snk_cyc_i(snk_cyc_i), .snk_stb_i(snk_stb_i), .snk_we_i(snk_we_i),
    .snk_stall_o(snk_stall_o), .snk_ack_o(snk_ack_o), .snk_err_o(snk_err_o),
    .snk_rty_o(snk_rty_o), .rx_data_o(rx_data_o), .rx_valid_o(rx_valid_o),
    .rx_dreq_i(rx_dreq_i), .rx_lost_o(rx_lost_o), .rx_latency_o(rx_latency_o),
    .rx_latency_valid_o(rx_latency_valid_o)
  );

  always #5 clk = ~clk;

  int          n_chk = 0, n_fail = 0;
  int          n_lost = 0, n_lat = 0, n_ack = 0;
  logic [27:0] last_lat = '0;
  logic [15:0] txq[$];
  logic [63:0] rxq[$];
  bit          cap_en = 1'b0;

  // Bus-side ack model and monitors, sampled on the falling edge.
  always @(negedge clk) begin
    ack_pend = src_cyc_o & src_stb_o & ~tb_stall;
    if (cap_en && src_cyc_o && src_stb_o && !src_stall_i) txq.push_back(src_dat_o);
    if (rx_valid_o) rxq.push_back(rx_data_o);
    if (rx_lost_o) n_lost++;
    if (rx_latency_valid_o) begin n_lat++; last_lat = rx_latency_o; end
    if (snk_ack_o) n_ack++;
  end
  always @(posedge clk) begin #1; tb_ack = ack_pend; end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] mk_rec(input int k);
    return {16'(k), 16'h1111, 16'h2222, ~16'(k)};
  endfunction

  task automatic tick(); @(posedge clk); #1; endtask

  task automatic wait_cyc(input string tag, input logic level);
    int n = 0;
    while (src_cyc_o !== level && n < 3000) begin tick(); n++; end
    check(tag, src_cyc_o, level);
  endtask

  task automatic send_frame(input logic [15:0] et, input logic [15:0] seq, input logic [27:0] ts,
                            input int n, input int base, input int limit);
    logic [15:0] w[$];
    logic [63:0] r;
    bit ok;
    int to;
    w = {};
    w.push_back(mac_rx[47:32]); w.push_back(mac_rx[31:16]); w.push_back(mac_rx[15:0]);
    w.push_back(mac_tx[47:32]); w.push_back(mac_tx[31:16]); w.push_back(mac_tx[15:0]);
    w.push_back(et); w.push_back(seq); w.push_back(ts[27:12]); w.push_back({4'h0, ts[11:0]});
    w.push_back(16'(n));
    for (int i = 0; i < n; i++) begin
      r = mk_rec(base + i);
      w.push_back(r[63:48]); w.push_back(r[47:32]); w.push_back(r[31:16]); w.push_back(r[15:0]);
    end
    if (limit == 0 || limit > w.size()) limit = w.size();
    sk_cyc = 1'b1;
    for (int i = 0; i < limit; i++) begin
      sk_dat = w[i];
      sk_stb = 1'b1;
      to = 0;
      do begin
        @(negedge clk); ok = !snk_stall_o;
        tick(); to++;
      end while (!ok && to < 200);
      if (!ok) check("sink_stall_timeout", 1'b1, 1'b0);
    end
    sk_stb = 1'b0;
    tick(); tick();
    sk_cyc = 1'b0;
    repeat (3) tick();
  endtask

  initial begin
    int n, k, cyc;
    // Reset state
    repeat (3) tick();
    check("rst_tx_dreq", tx_dreq_o, 1'b0);
    check("rst_src_cyc", src_cyc_o, 1'b0);
    check("rst_src_stb", src_stb_o, 1'b0);
    check("rst_snk_stall", snk_stall_o, 1'b0);
    check("rst_snk_ack", snk_ack_o, 1'b0);
    check("rst_rx_valid", rx_valid_o, 1'b0);
    check("rst_rx_latency", rx_latency_o, 28'h0);
    rst = 1'b1;
    tick();
    check("tx_dreq_after_rst", tx_dreq_o, 1'b1);

    // Eight back-to-back records form one threshold frame
    tm_cycles_i = 28'h0ABCDEF;
    cap_en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tx_valid_i = 1'b1; tx_data_i = mk_rec(i);
      tick();
    end
    tx_valid_i = 1'b0;
    wait_cyc("frame8_start", 1'b1);
    wait_cyc("frame8_end", 1'b0);
    check("frame8_len", txq.size(), 43);
    check("frame8_dst0", txq[0], 16'h0211);
    check("frame8_dst2", txq[2], 16'h4455);
    check("frame8_src0", txq[3], 16'h0266);
    check("frame8_src2", txq[5], 16'h99AA);
    check("frame8_etype", txq[6], 16'hDBFF);
    check("frame8_seq", txq[7], 16'h0000);
    check("frame8_ts_hi", txq[8], 16'h0ABC);
    check("frame8_ts_lo", txq[9], 16'h0DEF);
    check("frame8_n", txq[10], 16'd8);
    check("frame8_r0w0", txq[11], 16'h0000);
    check("frame8_r0w1", txq[12], 16'h1111);
    check("frame8_r0w3", txq[14], 16'hFFFF);
    check("frame8_r7w3", txq[42], 16'hFFF8);

    // Three records then idle: timeout flush
    txq = {};
    @(negedge clk); tx_valid_i = 1'b1; tx_data_i = mk_rec(100);
    @(posedge clk); n = 0; #1 tx_data_i = mk_rec(101);
    @(posedge clk); n++; #1 tx_data_i = mk_rec(102);
    @(posedge clk); n++; #1 tx_valid_i = 1'b0;
    while (!src_stb_o && n < 700) begin @(posedge clk); n++; #1; end
    check("timeout_launch_cycles", n, 512);
    wait_cyc("timeout_frame_end", 1'b0);
    check("timeout_len", txq.size(), 23);
    check("timeout_seq", txq[7], 16'd1);
    check("timeout_n", txq[10], 16'd3);
    check("timeout_r0w0", txq[11], 16'h0064);
    check("timeout_r2w3", txq[22], 16'hFF99);
    cap_en = 1'b0;

    // Sink-side frames driven directly
    rx_dreq_i = 1'b1;
    n_ack = 0;
    tm_cycles_i = 28'h0000010;
    send_frame(ethertype, 16'd0, 28'h0FFFFFF0, 2, 200, 0);
    check("rxA_count", rxq.size(), 2);
    check("rxA_rec0", rxq[0], mk_rec(200));
    check("rxA_rec1", rxq[1], mk_rec(201));
    check("rxA_lat_pulses", n_lat, 1);
    check("rxA_latency_wrap", last_lat, 28'h20);
    check("rxA_acks", n_ack, 19);
    check("rxA_lost", n_lost, 0);

    send_frame(16'h1234, 16'd1, 28'h0, 2, 300, 0);
    check("rxB_acks", n_ack, 38);
    check("rxB_no_records", rxq.size(), 2);
    check("rxB_no_latency", n_lat, 1);
    check("rxB_lost", n_lost, 0);

    send_frame(ethertype, 16'd2, 28'h0000100, 1, 210, 0);
    check("rxC_lost_once", n_lost, 1);
    check("rxC_rec", rxq[2], mk_rec(210));
    check("rxC_lat_pulses", n_lat, 2);
    check("rxC_latency", last_lat, 28'hFFFFF10);

    send_frame(ethertype, 16'd3, 28'h0, 2, 220, 16);
    check("rxD_count", rxq.size(), 4);
    check("rxD_rec", rxq[3], mk_rec(220));
    check("rxD_no_latency", n_lat, 2);
    check("rxD_no_lost", n_lost, 1);
    check("rxD_acks", n_ack, 69);

    // Loopback: 40 records, random valid and consumer ready
    rst = 1'b0; tick(); tick(); rst = 1'b1;
    rxq = {}; n_lost = 0; n_lat = 0;
    loopback = 1'b1;
    k = 0; cyc = 0;
    while ((k < 40 || rxq.size() < 40) && cyc < 30000) begin
      tx_valid_i = 1'b0;
      if (k < 40 && tx_dreq_o && $urandom_range(1, 0) == 1) begin
        tx_valid_i = 1'b1; tx_data_i = mk_rec(k); k++;
      end
      rx_dreq_i = ($urandom_range(99, 0) < 80);
      tick(); cyc++;
    end
    tx_valid_i = 1'b0; rx_dreq_i = 1'b1;
    repeat (5) tick();
    check("loop_count", rxq.size(), 40);
    for (int i = 0; i < 40; i++) check($sformatf("loop_rec%0d", i), rxq[i], mk_rec(i));
    check("loop_lost", n_lost, 0);
    check("loop_latency_seen", n_lat > 0, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
